// File: rtl/pug_vga_stream_out_if.sv
// Pixel stream handshake between the pixel generator (master) and the VGA output block (slave).
interface pug_vga_stream_out_if;
    logic [23:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        empty;
    logic        valid;
    logic        ready;

    modport master (output data, output startofpacket, output endofpacket,
                    output empty, output valid, input ready);
    modport slave  (input data, input startofpacket, input endofpacket,
                    input empty, input valid, output ready);
endinterface

// File: rtl/pug_vga_stream_out.sv
// Streams framed pixel data through a small FIFO onto VGA timing, locking each
// frame's startofpacket word to pixel (0,0) and flagging underflow/framing errors.
module pug_vga_stream_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    pug_vga_stream_out_if.slave      stream,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blank_n,
    output logic                     vga_sync_n,
    output logic                     vga_clk,
    output logic                     underflow,
    output logic                     sync_error
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic            pix_en_r;
    logic [HW-1:0]   h_cnt_r;
    logic [VW-1:0]   v_cnt_r;
    logic [0:0]      state_r;
    logic [25:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [23:0]     rgb_r;
    logic            hs_r;
    logic            vs_r;
    logic            blank_n_r;
    logic            underflow_r;
    logic            sync_error_r;

    logic            ready_s;
    logic            push_s;
    logic            empty_s;
    logic            full_s;
    logic [25:0]     head_s;
    logic            head_sop_s;
    logic            head_eop_s;
    logic            active_s;
    logic            origin_s;
    logic            last_px_s;
    logic            run_px_s;
    logic            pop_s;
    logic [0:0]      state_nxt_s;
    logic [23:0]     rgb_nxt_s;
    logic            set_uf_s;
    logic            set_se_s;
    logic            unused_s;

    assign unused_s    = stream.empty;
    assign empty_s     = (count_r == {(AW + 1){1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign ready_s     = !full_s && !reset;
    assign stream.ready = ready_s;
    assign push_s      = stream.valid && ready_s;
    assign head_s      = mem_r[rd_ptr_r];
    assign head_sop_s  = head_s[25];
    assign head_eop_s  = head_s[24];
    assign active_s    = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    assign origin_s    = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    assign last_px_s   = (h_cnt_r == H_ACT_LAST) && (v_cnt_r == V_ACT_LAST);

    // An active pixel is consumed from the stream when running, or when locking onto a SOP at (0,0).
    assign run_px_s = pix_en_r && active_s &&
                      ((state_r == ST_RUN) || (origin_s && !empty_s && head_sop_s));

    // Pixel decision: pop/discard, next colour, next state and error flag sets.
    always_comb begin
        pop_s       = 1'b0;
        state_nxt_s = state_r;
        rgb_nxt_s   = 24'h000000;
        set_uf_s    = 1'b0;
        set_se_s    = 1'b0;
        if (run_px_s) begin
            if (empty_s) begin
                set_uf_s    = 1'b1;
                state_nxt_s = ST_SYNC;
            end else if (head_sop_s && !origin_s) begin
                // Early SOP is kept at the head so the next frame can lock onto it.
                set_se_s    = 1'b1;
                state_nxt_s = ST_SYNC;
            end else begin
                pop_s       = 1'b1;
                rgb_nxt_s   = head_s[23:0];
                if (head_eop_s != last_px_s) begin
                    set_se_s    = 1'b1;
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
        end else if ((state_r == ST_SYNC) && !empty_s && !head_sop_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Pixel enable and horizontal/vertical raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_r <= 1'b0;
            h_cnt_r  <= {HW{1'b0}};
            v_cnt_r  <= {VW{1'b0}};
        end else begin
            pix_en_r <= ~pix_en_r;
            if (pix_en_r) begin
                if (h_cnt_r == H_LAST) begin
                    h_cnt_r <= {HW{1'b0}};
                    if (v_cnt_r == V_LAST) begin
                        v_cnt_r <= {VW{1'b0}};
                    end else begin
                        v_cnt_r <= v_cnt_r + VW'(1);
                    end
                end else begin
                    h_cnt_r <= h_cnt_r + HW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {stream.startofpacket, stream.endofpacket, stream.data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame-lock state, sticky flags and registered VGA outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_SYNC;
            rgb_r        <= 24'h000000;
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            blank_n_r    <= 1'b0;
            underflow_r  <= 1'b0;
            sync_error_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (set_uf_s) begin
                underflow_r <= 1'b1;
            end
            if (set_se_s) begin
                sync_error_r <= 1'b1;
            end
            if (pix_en_r) begin
                rgb_r     <= rgb_nxt_s;
                hs_r      <= !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
                vs_r      <= !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
                blank_n_r <= active_s;
            end
        end
    end

    assign vga_r       = rgb_r[23:16];
    assign vga_g       = rgb_r[15:8];
    assign vga_b       = rgb_r[7:0];
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign vga_blank_n = blank_n_r;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = pix_en_r;
    assign underflow   = underflow_r;
    assign sync_error  = sync_error_r;
endmodule

// File: doc/pug_vga_stream_out.md
PUG_VGA_STREAM_OUT -- requirements
Module: pug_vga_stream_out

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: horizontal sync width
- H_BP 48: horizontal back porch
- V_ACTIVE 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vertical sync width
- V_BP 33: vertical back porch
- FIFO_DEPTH 8: input buffer entries, power of 2

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: single clock (50 MHz).
- reset in 1: synchronous, active-high.
- data in 24: pixel {red, green, blue}, from the pixel generator.
- startofpacket in 1: first pixel of a frame.
- endofpacket in 1: last pixel of a frame.
- empty in 1: ignored.
- valid in 1: data is valid.
- ready out 1: block accepts a word this cycle.
- vga_r out 8: red.
- vga_g out 8: green.
- vga_b out 8: blue.
- vga_hs out 1: horizontal sync, active-low.
- vga_vs out 1: vertical sync, active-low.
- vga_blank_n out 1: high in the active region.
- vga_sync_n out 1: constant 0.
- vga_clk out 1: pixel clock, equal to pix_en.
- underflow out 1: sticky flag, FIFO empty at an active pixel.
- sync_error out 1: sticky flag, packet framing mismatch.

Function
REQ-003 pix_en SHALL toggle every clk (reset value 0); timing counters and all VGA outputs SHALL update only on clk edges where pix_en=1.
REQ-004 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps, counting 0..524 and wrapping to 0.
REQ-005 Active region SHALL be h_cnt<640 and v_cnt<480.
REQ-006 vga_hs SHALL be 0 for h_cnt 656..751; vga_vs SHALL be 0 for v_cnt 490..491.
REQ-007 VGA outputs SHALL be registered from the current counter values, giving 1 pixel period of latency; hs, vs, blank_n and rgb SHALL stay mutually aligned.
REQ-008 A word SHALL be accepted when valid=1 and ready=1; ready SHALL equal (FIFO not full) and (not reset).
REQ-009 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-010 The FIFO SHALL store {startofpacket, endofpacket, data} per entry; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 The state machine SHALL have two states, SYNC and RUN; the reset state SHALL be SYNC.
REQ-012 SYNC behaviour:
- Pop, with discard, any head word whose startofpacket=0, at most one per clk.
- Hold a head word whose startofpacket=1.
- Enter RUN on the pix_en cycle where h_cnt=0, v_cnt=0 and the head has startofpacket=1.
REQ-013 RUN behaviour:
- Pop one word per active pixel.
- Drive rgb from the popped word.
- Pop nothing outside the active region.
REQ-014 In SYNC, active pixels SHALL output rgb=0.
REQ-015 Blanking pixels SHALL output rgb=0 in both states.
REQ-016 RUN, FIFO empty at an active pixel:
- Output rgb=0.
- Set underflow=1.
- Go to SYNC.
REQ-017 RUN, head has startofpacket=1 at any active pixel other than (0,0):
- Do not pop it.
- Set sync_error=1.
- Output rgb=0.
- Go to SYNC.
REQ-018 RUN, popped word's endofpacket does not equal (h_cnt=639 and v_cnt=479):
- Set sync_error=1.
- Go to SYNC after the current pixel is output.
REQ-019 underflow and sync_error SHALL clear only on reset.

Reset
REQ-020 While reset=1, at the next clk:
- pix_en=0, h_cnt=0, v_cnt=0, FIFO empty, state=SYNC.
- ready=0, vga_r=vga_g=vga_b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_sync_n=0.
- underflow=0, sync_error=0.
REQ-021 Reset asserted mid-frame SHALL take effect on the next clk; buffered words SHALL be discarded and the state SHALL be SYNC.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset: hold reset 3 clks -> all outputs equal the REQ-020 values; ready=1 on the first clk after release.
- Timing: free-run 2 frames -> vga_hs low for 192 clks of every 1600-clk line; vga_vs low for 2 lines of 525; blank_n high for 1280 clks per active line.
- Lock: feed a 640x480 incrementing stream, valid=1 throughout, first startofpacket at an arbitrary time -> first displayed pixel (0,0) equals the SOP word; pixel (639,479) carries endofpacket; both flags stay 0 over 3 frames.
- Underflow: drop valid for 100 clks in the middle of line 10 -> rgb=0 from the first starved pixel; underflow=1; relock at the next (0,0) with a SOP word.
- Stray SOP: inject startofpacket at pixel 20 of line 5 -> sync_error=1; that word is displayed at the next frame's (0,0).
- Mid-frame reset: assert reset at line 200 -> REQ-020 values; relock at the next SOP frame boundary.
